// File: rtl/serial_transmitter_4bit.sv
// 4-bit LSB-first serial transmitter with valid/ready load handshake.
// Define SERIAL_TRANSMITTER_PARITY_EN to append an even-parity bit.
module serial_transmitter_4bit #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clockpulse,
  input  logic       clear,
  input  logic       loadValid,
  input  logic [3:0] loadData,
  output logic       loadReady,
  output logic       serialOutput,
  output logic       serialValid,
  output logic       frameDone,
  output logic [2:0] bitCount
);

`ifdef SERIAL_TRANSMITTER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE, SHIFT, PARITY, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, SHIFT, DONE
  } state_t;
`endif

  state_t     state;
  logic [3:0] shreg;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
  logic       par;
`endif

  // Outputs are registered: each transition loads the values of the
  // state being entered.
  always_ff @(posedge clockpulse) begin
    if (!clear) begin
      state        <= IDLE;
      shreg        <= 4'd0;
      bitCount     <= 3'd0;
      serialValid  <= 1'b0;
      frameDone    <= 1'b0;
      loadReady    <= 1'b1;
      serialOutput <= IDLE_LEVEL;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (loadValid) begin
            state        <= SHIFT;
            shreg        <= loadData;
            bitCount     <= 3'd0;
            loadReady    <= 1'b0;
            serialValid  <= 1'b1;
            serialOutput <= loadData[0];
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            par          <= ^loadData;
`endif
          end
        end
        SHIFT: begin
          shreg <= {1'b0, shreg[3:1]};
          if (bitCount == 3'd3) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            state        <= PARITY;
            bitCount     <= 3'd4;
            serialOutput <= par;
`else
            state        <= DONE;
            bitCount     <= 3'd0;
            serialValid  <= 1'b0;
            frameDone    <= 1'b1;
            serialOutput <= IDLE_LEVEL;
`endif
          end else begin
            bitCount     <= bitCount + 3'd1;
            serialOutput <= shreg[1];
          end
        end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
        PARITY: begin
          state        <= DONE;
          bitCount     <= 3'd0;
          serialValid  <= 1'b0;
          frameDone    <= 1'b1;
          serialOutput <= IDLE_LEVEL;
        end
`endif
        DONE: begin
          state     <= IDLE;
          frameDone <= 1'b0;
          loadReady <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          bitCount     <= 3'd0;
          serialValid  <= 1'b0;
          frameDone    <= 1'b0;
          loadReady    <= 1'b1;
          serialOutput <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_transmitter_4bit.md
SERIAL_TRANSMITTER_4BIT -- requirements
Module: serial_transmitter_4bit

Interface
REQ-001 Parameter: IDLE_LEVEL, default 1'b0, serialOutput level whenever no bit is being sent.
REQ-002 Port: clockpulse  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: clear  input  1  reset, synchronous, active-low.
REQ-004 Port: loadValid  input  1  parallel word offered for transmission.
REQ-005 Port: loadData  input  4  parallel word; bit0 is sent first.
REQ-006 Port: loadReady  output  1  transmitter idle, word accepted when loadValid=1.
REQ-007 Port: serialOutput  output  1  serial data line.
REQ-008 Port: serialValid  output  1  high while serialOutput carries a frame bit; drives the receiving shift register's clock enable.
REQ-009 Port: frameDone  output  1  one-cycle pulse after the last frame bit.
REQ-010 Port: bitCount  output  3  index of the bit currently on serialOutput (0-3 data, 4 parity).

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, PARITY, DONE; encoding is implementation choice.
REQ-012 IDLE: loadReady=1, serialValid=0, serialOutput=IDLE_LEVEL, bitCount=0.
REQ-013 Handshake: loadValid=1 and loadReady=1 at edge k SHALL capture loadData into a 4-bit shift register, clear bitCount, enter SHIFT.
REQ-014 loadValid with loadReady=0 SHALL be ignored; the word is neither captured nor queued.
REQ-015 SHIFT: serialOutput=shiftReg[0], serialValid=1, loadReady=0; each edge shifts right (zero fill) and increments bitCount.
REQ-016 Data bits SHALL appear LSB-first in cycles k+1..k+4 (one bit per clock, no gaps).
REQ-017 After bitCount=3, the next state SHALL be PARITY when parity is compiled in, else DONE.
REQ-018 PARITY: serialOutput=XOR of the four captured bits (even parity), serialValid=1, bitCount=4, for one cycle.
REQ-019 DONE: frameDone=1, serialValid=0, loadReady=0, serialOutput=IDLE_LEVEL for exactly one cycle, then IDLE.
REQ-020 Handshake-to-next-loadReady SHALL be 6 cycles without parity, 7 with parity; back-to-back frames SHALL be separated by at least one DONE and one IDLE cycle.
REQ-021 loadData changes after capture SHALL NOT affect the frame in flight.
REQ-022 All outputs SHALL be registered or decoded purely from registered state; no combinational path from loadValid/loadData to any output except none (loadReady depends on state only).

Reset
REQ-023 clear=0 at a rising edge SHALL force IDLE, shiftReg=0, bitCount=0, serialValid=0, frameDone=0, loadReady=1, serialOutput=IDLE_LEVEL from the next cycle.
REQ-024 Reset mid-frame SHALL abort the frame with no frameDone pulse and no further frame bits.
REQ-025 loadValid=1 during a reset edge SHALL NOT capture; capture is possible from the first edge with clear=1.

Configuration
REQ-026 Macro SERIAL_TRANSMITTER_PARITY_EN defined: PARITY state present, frame = 4 data + 1 parity bit.
REQ-027 Macro undefined: PARITY state and parity logic absent, frame = 4 data bits, bitCount never exceeds 3.

Verification
REQ-028 No parity, load 4'b1011 -> serialOutput 1,1,0,1 with serialValid=1 for 4 cycles, frameDone next cycle, loadReady 6 cycles after handshake.
REQ-029 Parity build, load 4'b1011 -> serialOutput 1,1,0,1 then parity 1, bitCount 0..4, frameDone after 5th bit.
REQ-030 loadValid held high with 4'b0110 then 4'b1001 -> second word sent only after DONE+IDLE; no bits dropped or merged.
REQ-031 loadValid pulsed with 4'b1111 while busy in SHIFT -> ignored; current frame unchanged.
REQ-032 clear=0 at bitCount=2 -> next cycle IDLE, serialValid=0, loadReady=1, no frameDone.
REQ-033 Loopback: transmitter serialOutput/serialValid into the 4-bit serial-in register (serial input at bit3, enable=serialValid) -> register equals loaded word after frame, for all 16 values.
